// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: func codes, sequencer states,
// iterative-unit op select and the default datapath width.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_NOR  = 4'd4;
    localparam logic [3:0] F_SLT  = 4'd5;
    localparam logic [3:0] F_SLTU = 4'd6;
    localparam logic [3:0] F_XOR  = 4'd7;
    localparam logic [3:0] F_MUL  = 4'd8;
    localparam logic [3:0] F_DIVU = 4'd9;
    localparam logic [3:0] F_REMU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIVU,
        MD_REMU
    } md_op_t;

    function automatic logic is_iter(input logic [3:0] f);
        return (f == F_MUL) || (f == F_DIVU) || (f == F_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add, LSB first) and restoring divide (MSB first).
// result presents the value produced by the current step, so the caller
// captures the final answer on the edge of the last step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] result
);

    md_op_t           op_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;

        // Trial subtract is one bit wider so its sign bit says "restore".
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr_q};
        rem_d    = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

        case (op_q)
            MD_MUL:  result = acc_d;
            MD_DIVU: result = quo_d;
            default: result = rem_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
        end else if (load) begin
            op_q     <= op;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            rem_q    <= '0;
            quo_q    <= a;
            dvsr_q   <= b;
        end else if (step) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops finish on the
// accept edge, MUL/DIVU/REMU run WIDTH iterations in alu_muldiv_iter.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             ovf_flag
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, alu_res, md_result;
    logic             alu_ovf, div0, md_load, md_step;
    md_op_t           md_op;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (func)
            F_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            F_AND:  alu_res = a & b;
            F_OR:   alu_res = a | b;
            F_NOR:  alu_res = ~(a | b);
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            F_XOR:  alu_res = a ^ b;
            // DIVU/REMU only take this path when b == 0.
            F_DIVU: alu_res = '1;
            F_REMU: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    assign div0 = ((func == F_DIVU) || (func == F_REMU)) && (b == '0);

    always_comb begin
        case (func)
            F_MUL:   md_op = MD_MUL;
            F_DIVU:  md_op = MD_DIVU;
            default: md_op = MD_REMU;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (md_load),
        .op    (md_op),
        .a     (a),
        .b     (b),
        .step  (md_step),
        .result(md_result)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        md_load = 1'b0;
        md_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter(func) && !div0) begin
                        md_load = 1'b1;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_CALC;
                    end else begin
                        out_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                md_step = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    out_d   = md_result;
                    zero_d  = (md_result == '0);
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign zero_flag = zero_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W      = 32;
    localparam int          MAXLAT = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   func;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero_flag;
    logic         ovf_flag;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .func     (func),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .zero_flag(zero_flag),
        .ovf_flag (ovf_flag)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] f, input logic [W-1:0] x, y,
                                  output logic [W-1:0] r, output logic ov, output int lat);
        longint sx, sy, s;
        longint smax, smin;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) << 31) - 1;
        smin = -(longint'(1) << 31);
        ov   = 1'b0;
        lat  = 1;
        case (f)
            4'd0: begin r = x + y; s = sx + sy; ov = (s > smax) || (s < smin); end
            4'd1: begin r = x - y; s = sx - sy; ov = (s > smax) || (s < smin); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = ~(x | y);
            4'd5: r = (sx < sy) ? 1 : 0;
            4'd6: r = (x < y) ? 1 : 0;
            4'd7: r = x ^ y;
            4'd8: begin r = x * y; lat = W + 1; end
            4'd9: begin
                if (y == 0) r = '1;
                else begin r = x / y; lat = W + 1; end
            end
            4'd10: begin
                if (y == 0) r = x;
                else begin r = x % y; lat = W + 1; end
            end
            default: r = '0;
        endcase
    endfunction

    // Drives one op, waits (bounded) for the result, samples it and drains it.
    // Junk is driven on the operand inputs while the op is in flight.
    task automatic do_op(input logic [3:0] f, input logic [W-1:0] oa, ob,
                         output logic [W-1:0] r, output logic z, ov, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a = oa;
        b = ob;
        func = f;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < MAXLAT) begin
            in_valid = 1'($urandom);
            a = $urandom;
            b = $urandom;
            func = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        r  = out;
        z  = zero_flag;
        ov = ovf_flag;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out !== '0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
        total++; if (zero_flag !== 1'b0 || ovf_flag !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b exp=00", zero_flag, ovf_flag);
        end
    endtask

    task automatic test_add_sub();
        logic [W-1:0] r; logic z, ov; int lat;
        do_op(4'd0, 32'h7FFF_FFFF, 32'h1, r, z, ov, lat);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_out got=%h exp=80000000", r); end
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL add_ovf_flag got=%b exp=1", ov); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL add_ovf_zero got=%b exp=0", z); end
        total++; if (lat != 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
        do_op(4'd1, 32'd5, 32'd5, r, z, ov, lat);
        total++; if (r !== '0) begin bad++; $display("FAIL sub_zero_out got=%h exp=0", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL sub_zero_flag got=%b exp=1", z); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL sub_zero_ovf got=%b exp=0", ov); end
    endtask

    task automatic test_slt();
        logic [W-1:0] r; logic z, ov; int lat;
        do_op(4'd5, 32'hFFFF_FFFF, 32'd1, r, z, ov, lat);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", r); end
        do_op(4'd6, 32'hFFFF_FFFF, 32'd1, r, z, ov, lat);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL sltu_zero got=%b exp=1", z); end
    endtask

    task automatic test_mul();
        logic [W-1:0] r; logic z, ov; int lat;
        do_op(4'd8, 32'h0001_2345, 32'h0000_0100, r, z, ov, lat);
        total++; if (r !== 32'h0123_4500) begin bad++; $display("FAIL mul_out got=%h exp=01234500", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        do_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, ov, lat);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL mul_ones got=%h exp=1", r); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL mul_ovf got=%b exp=0", ov); end
    endtask

    task automatic test_div();
        logic [W-1:0] r; logic z, ov; int lat;
        do_op(4'd9, 32'd100, 32'd7, r, z, ov, lat);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_out got=%0d exp=14", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        do_op(4'd10, 32'd100, 32'd7, r, z, ov, lat);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_out got=%0d exp=2", r); end
        total++; if (lat != 33) begin bad++; $display("FAIL remu_latency got=%0d exp=33", lat); end
        do_op(4'd9, 32'd42, 32'd0, r, z, ov, lat);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL divu_by0_latency got=%0d exp=1", lat); end
        do_op(4'd10, 32'd42, 32'd0, r, z, ov, lat);
        total++; if (r !== 32'd42) begin bad++; $display("FAIL remu_by0 got=%0d exp=42", r); end
        total++; if (lat != 1) begin bad++; $display("FAIL remu_by0_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, x, y; logic z, ov, eov; int lat, elat;
        logic [3:0] f;
        for (int i = 0; i < 60; i++) begin
            f = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = '0;
            if ($urandom_range(0, 5) == 0) x = x >> $urandom_range(0, 31);
            model(f, x, y, er, eov, elat);
            do_op(f, x, y, r, z, ov, lat);
            total++; if (r !== er) begin bad++; $display("FAIL rand_out f=%0d a=%h b=%h got=%h exp=%h", f, x, y, r, er); end
            total++; if (z !== (er == '0)) begin bad++; $display("FAIL rand_zero f=%0d got=%b exp=%b", f, z, (er == '0)); end
            total++; if (ov !== eov) begin bad++; $display("FAIL rand_ovf f=%0d a=%h b=%h got=%b exp=%b", f, x, y, ov, eov); end
            total++; if (lat != elat) begin bad++; $display("FAIL rand_latency f=%0d got=%0d exp=%0d", f, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; a = 32'd3; b = 32'd4; func = 4'd0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out !== 32'd7) begin
            bad++; $display("FAIL bp_first got=%b/%h exp=1/7", out_valid, out);
        end
        a = 32'd100; b = 32'd1; func = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out !== 32'd7 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/7", i, out_valid, out);
            end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1; a = 32'd1; b = 32'd1; func = 4'd0;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_after_hs got=v%b/r%b exp=v0/r1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out !== 32'd2) begin
            bad++; $display("FAIL bp_next_op got=%b/%h exp=1/2", out_valid, out);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        logic [W-1:0] r; logic z, ov; int lat;
        @(negedge clk);
        in_valid = 1'b1; a = 32'd7; b = 32'd9; func = 4'd8;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        total++; if (out !== '0) begin bad++; $display("FAIL rst_mid_out got=%h exp=0", out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_release got=r%b/v%b exp=r1/v0", in_ready, out_valid);
        end
        do_op(4'd8, 32'd7, 32'd9, r, z, ov, lat);
        total++; if (r !== 32'd63 || lat != 33) begin
            bad++; $display("FAIL rst_mid_rerun got=%0d/%0d exp=63/33", r, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; func = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add_sub();
        test_slt();
        test_mul();
        test_div();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
